// File: rtl/operand_rotate_sequencer.sv
// Four-operand rotate stage: captures a/b/c/d, applies in_steps positional rotations, then
// holds the result for a valid/ready consumer. Define ROT_DIR_EN to add a per-packet in_dir.
module operand_rotate_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [WIDTH-1:0]  in_c,
  input  logic [WIDTH-1:0]  in_d,
  input  logic [STEP_W-1:0] in_steps,
`ifdef ROT_DIR_EN
  input  logic              in_dir,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [WIDTH-1:0]  out_c,
  output logic [WIDTH-1:0]  out_d,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, b_q, c_q, d_q;
  logic [WIDTH-1:0]   a_d, b_d, c_d, d_d;
  logic               dir_q, dir_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          d_d     = in_d;
          cnt_d   = in_steps;
`ifdef ROT_DIR_EN
          dir_d   = in_dir;
`else
          dir_d   = 1'b0;
`endif
          state_d = (in_steps != '0) ? StRotate : StDone;
        end
      end
      StRotate: begin
        if (dir_q) begin
          a_d = d_q;
          b_d = a_q;
          c_d = b_q;
          d_d = c_q;
        end else begin
          a_d = b_q;
          b_d = c_q;
          c_d = d_q;
          d_d = a_q;
        end
        cnt_d = cnt_q - STEP_W'(1);
        if (cnt_q == STEP_W'(1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      dir_q   <= dir_d;
    end
  end

  // Handshake outputs depend on state only, never on in_*.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;
  assign out_d     = d_q;

endmodule

// File: tb/tb_operand_rotate_sequencer.sv
// Directed bench for operand_rotate_sequencer: latency, rotation order, backpressure,
// back-to-back throughput and mid-flight reset; direction test when ROT_DIR_EN is defined.
module tb_operand_rotate_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b, in_c, in_d;
  logic [1:0] in_steps;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_rotate_sequencer #(.WIDTH(8), .STEP_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_c     (in_c),
    .in_d     (in_d),
    .in_steps (in_steps),
`ifdef ROT_DIR_EN
    .in_dir   (in_dir),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_c    (out_c),
    .out_d    (out_d),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {out_a, out_b, out_c, out_d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one packet for the accept edge; leaves the bench 1 time unit after that edge.
  task automatic send(input logic [7:0] a, b, c, d, input logic [1:0] s, input logic dir);
    in_a = a; in_b = b; in_c = c; in_d = d; in_steps = s; in_dir = dir;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = 8'hee; in_b = 8'hee; in_c = 8'hee; in_d = 8'hee; in_steps = 2'd0; in_dir = 1'b0;
  endtask

  // Cycles after the accept edge until out_valid is seen; checks in_ready stays low meanwhile.
  task automatic wait_valid(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      check_eq({tag, "_in_ready_rot"}, {31'd0, in_ready}, 32'd0);
      step();
      lat++;
    end
  endtask

  int lat;
  int acc_edges[$];
  int seen;
  logic rdy_prev;
  logic [31:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_steps = '0; in_dir = 1'b0;
    #2;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_outs", outs(), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // steps=0
    send(8'd30, 8'd20, 8'd15, 8'd5, 2'd0, 1'b0);
    wait_valid("s0", lat);
    check_eq("s0_latency", lat, 32'd1);
    check_eq("s0_outs", outs(), {8'd30, 8'd20, 8'd15, 8'd5});
    check_eq("s0_busy", {31'd0, busy}, 32'd1);
    step();
    check_eq("s0_back_idle", {31'd0, in_ready}, 32'd1);

    // steps=1
    send(8'd30, 8'd20, 8'd15, 8'd5, 2'd1, 1'b0);
    wait_valid("s1", lat);
    check_eq("s1_latency", lat, 32'd2);
    check_eq("s1_outs", outs(), {8'd20, 8'd15, 8'd5, 8'd30});
    step();

    // steps=3 under backpressure, with an ignored packet attempt
    out_ready = 1'b0;
    send(8'd30, 8'd20, 8'd15, 8'd5, 2'd3, 1'b0);
    wait_valid("s3", lat);
    check_eq("s3_latency", lat, 32'd4);
    held = outs();
    check_eq("s3_outs", held, {8'd5, 8'd30, 8'd20, 8'd15});
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_a = 8'd1; in_b = 8'd2; in_c = 8'd3; in_d = 8'd4; in_steps = 2'd0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_outs", outs(), {8'd5, 8'd30, 8'd20, 8'd15});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check_eq("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check_eq("bp_release_outs", outs(), {8'd5, 8'd30, 8'd20, 8'd15});

    // Back-to-back, steps=2, in_valid held high
    in_a = 8'd30; in_b = 8'd20; in_c = 8'd15; in_d = 8'd5; in_steps = 2'd2;
    in_valid = 1'b1;
    seen = 0;
    for (int n = 0; n < 13; n++) begin
      rdy_prev = in_ready;
      if (out_valid) begin
        seen++;
        check_eq("b2b_outs", outs(), {8'd15, 8'd5, 8'd30, 8'd20});
      end
      step();
      if (rdy_prev) acc_edges.push_back(n);
    end
    in_valid = 1'b0;
    check_eq("b2b_accepts", acc_edges.size(), 32'd4);
    check_eq("b2b_results", seen, 32'd3);
    if (acc_edges.size() >= 3) begin
      check_eq("b2b_gap1", acc_edges[1] - acc_edges[0], 32'd4);
      check_eq("b2b_gap2", acc_edges[2] - acc_edges[1], 32'd4);
    end
    while (!in_ready && seen < 40) begin
      step();
      seen++;
    end
    check_eq("b2b_drained", {31'd0, in_ready}, 32'd1);

    // Reset during the 2nd ROTATE cycle of a steps=3 packet
    send(8'd30, 8'd20, 8'd15, 8'd5, 2'd3, 1'b0);
    step();
    check_eq("mr_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_outs", outs(), 32'd0);
    check_eq("mr_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mr_busy", {31'd0, busy}, 32'd0);
    check_eq("mr_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("mr_no_valid", {31'd0, out_valid}, 32'd0);
    end

`ifdef ROT_DIR_EN
    send(8'd30, 8'd20, 8'd15, 8'd5, 2'd1, 1'b1);
    wait_valid("dir", lat);
    check_eq("dir_latency", lat, 32'd2);
    check_eq("dir_outs", outs(), {8'd5, 8'd30, 8'd20, 8'd15});
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_rotate_sequencer.md
Name: operand_rotate_sequencer

Overview:
- Upstream operand stage that feeds the four-operand a/b/c/d datapath.
- Accepts a packet of four WIDTH-bit operands over a valid/ready handshake.
- Applies a programmable number of simultaneous rotations, one per clock. Each rotation is the non-blocking swap a<=b, b<=c, c<=d, d<=a.
- Presents the rotated set downstream over a valid/ready handshake and holds it until consumed.

Parameters:
- WIDTH, 8, bit width of each operand.
- STEP_W, 2, width of the rotation-count field; the maximum count is 2^STEP_W-1.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has a packet.
- in_ready  output  1  block can accept a packet.
- in_a, in_b, in_c, in_d  input  WIDTH each  operands.
- in_steps  input  STEP_W  number of rotations to apply.
- out_valid  output  1  result is available.
- out_ready  input  1  downstream accepts the result.
- out_a, out_b, out_c, out_d  output  WIDTH each  rotated operands, registered.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_a..out_d=0; step counter=0.
- Accept: occurs on a rising edge with in_valid & in_ready.
  - Operands are captured into out_a..out_d.
  - Counter is loaded from in_steps.
- FSM states: IDLE, ROTATE, DONE.
  - IDLE: in_ready=1. On accept, go to ROTATE if in_steps!=0, otherwise go to DONE.
  - ROTATE: in_ready=0, busy=1. Each cycle performs one rotation on all four registers simultaneously: out_a<=out_b, out_b<=out_c, out_c<=out_d, out_d<=out_a. The counter decrements by 1. When the counter is 1 at the edge, go to DONE.
  - DONE: out_valid=1, in_ready=0, busy=1. Outputs are stable. When out_ready=1, return to IDLE on that edge with out_valid=0.
- Latency:
  - out_valid rises exactly in_steps+1 cycles after the accept edge.
  - Throughput is one packet per in_steps+2 cycles when out_ready is held high.
- Rotation arithmetic:
  - The rotation is purely positional; there is no arithmetic and no width change.
  - in_steps=4 (when STEP_W>2) returns the original order. Steps are not reduced modulo 4; every rotation is applied.
- Backpressure: when out_ready=0 in DONE, the block stays in DONE indefinitely with outputs frozen.
- in_valid outside IDLE: ignored. in_ready=0, so no capture and no data corruption.
- in_* values sampled only on the accept edge; changes at other times have no effect.
- Reset mid-operation: rst_n low in ROTATE or DONE returns immediately to reset values. The in-flight packet is discarded and no out_valid pulse appears.
- No combinational path from in_* to out_*. Ready/valid outputs are decoded from state only.

Optional Feature:
- Macro: ROT_DIR_EN.
- Defined:
  - Adds input port in_dir (1 bit), sampled with the packet on the accept edge and held for the packet.
  - in_dir=0 selects left rotation, as above.
  - in_dir=1 selects right rotation: out_a<=out_d, out_b<=out_a, out_c<=out_b, out_d<=out_c.
- Undefined: no in_dir port; rotation is always left.
- All other timing is identical in both builds.

Test Plan:
- Reset, then send a=30, b=20, c=15, d=5, steps=0, out_ready=1 -> out_valid on the 1st cycle after accept; out=30,20,15,5.
- Same operands, steps=1 -> out_valid 2 cycles after accept; out=20,15,5,30.
- Same operands, steps=3, out_ready=0 for 5 cycles then 1:
  - out=5,30,20,15, stable while out_valid=1.
  - in_ready=0 throughout.
  - A second in_valid pulse with 1,2,3,4 during this time is ignored.
- Back-to-back packets with in_valid held high and out_ready=1, steps=2 -> accepts spaced 4 cycles apart; each output=15,5,30,20.
- Assert rst_n=0 during the 2nd ROTATE cycle of a steps=3 packet -> outputs zero immediately, state IDLE, in_ready=1, no out_valid.
- With ROT_DIR_EN defined: 30,20,15,5, steps=1, in_dir=1 -> out=5,30,20,15.
